// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the board FIFO access controller.
package fifo_ctrl_pkg;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_DEPTH     = 512;
    localparam int DEF_DB_CYCLES = 500000;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_e;
    typedef enum logic {DIR_WR, DIR_RD} dir_e;
endpackage

// File: rtl/fifo_access_ctrl_btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, consecutive-cycle debounce and
// a one-cycle pulse when the debounced level rises.
module btn_conditioner
    import fifo_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic            sync1, sync2, level;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle where the synced level agrees with the debounced one restarts the count
            if (sync2 != level) begin
                if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    level  <= sync2;
                    rise   <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/fifo_access_ctrl.sv
// Serializes button-driven writes/reads to the board FIFO, tracks exact
// occupancy, and blocks overflow/underflow with sticky error flags.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = 10,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_btn,
    input  logic              rd_btn,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              busy
);
    state_e state, next_state;
    dir_e   last_served;
    logic   wr_rise, rd_rise;
    logic   pend_wr, pend_rd;
    logic   grant_wr, grant_rd;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_wr_btn (
        .clk(clk), .reset(reset), .btn(wr_btn), .rise(wr_rise)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_rd_btn (
        .clk(clk), .reset(reset), .btn(rd_btn), .rise(rd_rise)
    );

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    // Strobes drop in the very cycle reset is sampled, not one later
    assign fifo_wrreq = (state == WR) && !reset;
    assign fifo_rdreq = (state == RD) && !reset;

    always_comb begin
        next_state = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_wr && (!pend_rd || last_served == DIR_RD)) begin
                    grant_wr = 1'b1;
                    if (!full) next_state = WR;
                end else if (pend_rd) begin
                    grant_rd = 1'b1;
                    if (!empty) next_state = RD;
                end
            end
            WR:      next_state = IDLE;
            RD:      next_state = RD_CAP;
            RD_CAP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pend_wr       <= 1'b0;
            pend_rd       <= 1'b0;
            last_served   <= DIR_RD;
            count         <= '0;
            fifo_data     <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state   <= next_state;
            pend_wr <= (pend_wr && !grant_wr) || wr_rise;
            pend_rd <= (pend_rd && !grant_rd) || rd_rise;
            if (grant_wr) begin
                last_served <= DIR_WR;
                if (full) err_overflow <= 1'b1;
                else      fifo_data    <= wr_data;
            end
            if (grant_rd) begin
                last_served <= DIR_RD;
                if (empty) err_underflow <= 1'b1;
            end
            if (state == WR) count <= count + 1'b1;
            if (state == RD) count <= count - 1'b1;
            rd_valid <= (state == RD_CAP);
            if (state == RD_CAP) rd_data <= fifo_q;
        end
    end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Randomized scoreboard bench for fifo_access_ctrl with a legacy-mode FIFO
// model and a queue-based reference of occupancy, arbitration and errors.
module tb_fifo_access_ctrl;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 512;
    localparam int CNT_W  = 10;
    localparam int DB     = 4;

    logic              clk = 1'b0, reset = 1'b1, wr_btn = 1'b0, rd_btn = 1'b0;
    logic [DATA_W-1:0] wr_data = '0, fifo_q = '0;
    logic              fifo_wrreq, fifo_rdreq, rd_valid, full, empty;
    logic              err_overflow, err_underflow, busy;
    logic [DATA_W-1:0] fifo_data, rd_data;
    logic [CNT_W-1:0]  count;

    fifo_access_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .wr_btn(wr_btn), .rd_btn(rd_btn),
        .wr_data(wr_data), .fifo_q(fifo_q), .fifo_wrreq(fifo_wrreq),
        .fifo_rdreq(fifo_rdreq), .fifo_data(fifo_data), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0, last_rd_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Legacy-mode FIFO: q updates the cycle after rdreq; cleared by the shared reset
    logic [DATA_W-1:0] mem_q[$];
    always @(posedge clk) begin
        if (reset) begin
            mem_q.delete();
            fifo_q <= '0;
        end else begin
            if (fifo_wrreq) mem_q.push_back(fifo_data);
            if (fifo_rdreq && mem_q.size() > 0) fifo_q <= mem_q.pop_front();
        end
    end

    // Reference model and scoreboard queues
    int                m_cnt;
    bit                m_ovf, m_unf, m_last_rd;
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] exp_wr[$], exp_rd[$];
    int                exp_ord[$];   // 0 = write strobe, 1 = read strobe

    task automatic m_wr(input logic [DATA_W-1:0] d);
        m_last_rd = 1'b0;
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else begin
            m_fifo.push_back(d); exp_wr.push_back(d); exp_ord.push_back(0); m_cnt++;
        end
    endtask

    task automatic m_rd();
        m_last_rd = 1'b1;
        if (m_cnt == 0) m_unf = 1'b1;
        else begin
            exp_rd.push_back(m_fifo.pop_front()); exp_ord.push_back(1); m_cnt--;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (fifo_wrreq) begin
            if (exp_ord.size() == 0 || exp_wr.size() == 0) chk("unexpected_wrreq", fifo_wrreq, 0);
            else begin
                chk("strobe_order_wr", exp_ord.pop_front(), 0);
                chk("fifo_data", fifo_data, exp_wr.pop_front());
            end
        end
        if (fifo_rdreq) begin
            last_rd_cyc = cyc;
            if (exp_ord.size() == 0) chk("unexpected_rdreq", fifo_rdreq, 0);
            else chk("strobe_order_rd", exp_ord.pop_front(), 1);
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) chk("unexpected_rd_valid", rd_valid, 0);
            else begin
                chk("rd_data", rd_data, exp_rd.pop_front());
                chk("rd_valid_latency", cyc - last_rd_cyc, 2);
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_count"}, count, m_cnt);
        chk({tag, "_full"}, full, (m_cnt == DEPTH));
        chk({tag, "_empty"}, empty, (m_cnt == 0));
        chk({tag, "_err_overflow"}, err_overflow, m_ovf);
        chk({tag, "_err_underflow"}, err_underflow, m_unf);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_undelivered"}, exp_ord.size() + exp_wr.size() + exp_rd.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_btn = 1'b0; rd_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_cnt = 0; m_ovf = 0; m_unf = 0; m_last_rd = 1'b1;
        m_fifo.delete(); exp_wr.delete(); exp_rd.delete(); exp_ord.delete();
    endtask

    task automatic press(input bit w, input bit r, input logic [DATA_W-1:0] d,
                         input bit bounce, input int hold, input string tag);
        wr_data = d;
        if (w && r) begin
            if (m_last_rd) begin m_wr(d); m_rd(); end
            else begin m_rd(); m_wr(d); end
        end else if (w) m_wr(d);
        else if (r) m_rd();
        if (bounce)
            for (int i = 0; i < 10; i++) begin
                wr_btn = w & (i % 2 == 0);
                rd_btn = r & (i % 2 == 0);
                repeat (2) @(posedge clk);
            end
        wr_btn = w; rd_btn = r;
        repeat (hold) @(posedge clk);
        wr_btn = 1'b0; rd_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1 check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_errs", {err_overflow, err_underflow}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {fifo_wrreq, fifo_rdreq, rd_valid}, 0);
        chk("rst_data", {rd_data, fifo_data}, 0);

        press(0, 1, 4'h0, 0, 12, "underflow");
        press(1, 0, 4'hA, 0, 20, "wr_A");
        press(1, 0, 4'h5, 1, 12, "wr_bounce");
        press(0, 1, 4'h0, 0, 12, "rd1");
        press(0, 1, 4'h0, 0, 12, "rd2");

        do_reset();
        press(1, 0, 4'h3, 0, 12, "wr_3");
        press(1, 0, 4'h7, 0, 12, "wr_7");
        press(0, 1, 4'h0, 0, 12, "rd_3");
        press(0, 1, 4'h0, 0, 12, "rd_7");

        do_reset();
        press(1, 0, 4'h1, 0, 12, "pre_tie1");
        press(1, 1, 4'h2, 0, 12, "tie1");
        press(1, 0, 4'h4, 0, 12, "pre_tie2");
        press(1, 1, 4'h6, 0, 12, "tie2");

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            press(op != 1, op != 0, 4'($urandom), 1'($urandom_range(0, 1)), 12, "rand");
        end

        do_reset();
        for (int i = 0; i < DEPTH; i++) press(1, 0, 4'($urandom), 0, 10, "fill");
        press(1, 0, 4'hF, 0, 12, "overflow");

        // Abort a read in flight with reset
        rd_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (fifo_rdreq) break;
        end
        chk("rd_strobe_seen", fifo_rdreq, 1);
        reset = 1'b1;
        #1 chk("rdreq_drop_on_reset", fifo_rdreq, 0);
        @(posedge clk);
        #1 reset = 1'b0; rd_btn = 1'b0;
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_empty", empty, 1);
        chk("abort_err_overflow", err_overflow, 0);
        repeat (5) @(posedge clk);
        #1 chk("abort_quiet", {fifo_wrreq, fifo_rdreq, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
